// File: rtl/pri_enc_sched.sv
// Registered priority-encoder scheduler: latches request pulses into a pending vector and serves one index per cycle over valid/ready.
// Fixed MSB-first priority by default; define PRI_ENC_SCHED_RR_EN for round-robin selection with a rotating pointer.
module pri_enc_sched #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d, clr;
  logic [W-1:0]   idx_q, idx_d, sel;
  logic           ovf_q, ovf_d;
  logic           load;

  assign load = (|pending_q) && ((state_q == EMPTY) || out_ready);

`ifdef PRI_ENC_SCHED_RR_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] sel_lo;
  logic         any_lo;

  // Indices at or below the pointer win first (highest of them), then wrap to the highest above it.
  always_comb begin
    sel    = '0;
    sel_lo = '0;
    any_lo = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) begin
        sel = W'(i);
        if (i <= int'(ptr_q)) begin
          sel_lo = W'(i);
          any_lo = 1'b1;
        end
      end
    end
    if (any_lo) sel = sel_lo;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = (sel == '0) ? W'(N - 1) : (sel - W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= W'(N - 1);
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) sel = W'(i);
    end
  end
`endif

  // A request landing on the bit being served re-arms it; only a hit on a bit that stays pending collides.
  always_comb begin
    clr       = load ? (N'(1) << sel) : '0;
    pending_d = (pending_q & ~clr) | req;
    ovf_d     = |(req & pending_q & ~clr);
    idx_d     = load ? sel : idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (out_ready && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
    out_idx   = idx_q;
    pending   = pending_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_pri_enc_sched.sv
// Directed bench for pri_enc_sched: an N=8 and an N=5 instance, expected indices queued at stimulus time and popped on each handshake.
module tb_pri_enc_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] req8, pend8;
  logic       rdy8, v8, ovf8;
  logic [2:0] idx8;
  logic [4:0] req5, pend5;
  logic       rdy5, v5, ovf5;
  logic [2:0] idx5;

  pri_enc_sched u8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .out_valid(v8), .out_ready(rdy8),
    .out_idx(idx8), .pending(pend8), .overflow(ovf8)
  );

  pri_enc_sched #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .out_valid(v5), .out_ready(rdy5),
    .out_idx(idx5), .pending(pend5), .overflow(ovf5)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pops and compares one expected index per accepted transfer, bounded by a cycle budget.
  task automatic drain(input bit five, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      if (five) begin
        if (v5 && rdy5) chk("idx5", 32'(idx5), 32'(exp_q.pop_front()));
      end else begin
        if (v8 && rdy8) chk("idx8", 32'(idx8), 32'(exp_q.pop_front()));
      end
      if (exp_q.size() == 0) break;
      if (n == budget) begin
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        break;
      end
      cyc();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req8 = '0; rdy8 = 1'b0; req5 = '0; rdy5 = 1'b0;
    cyc(); cyc();
    chk("rst_valid", 32'(v8), 32'd0);
    chk("rst_idx", 32'(idx8), 32'd0);
    chk("rst_pend", 32'(pend8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    chk("rst_valid5", 32'(v5), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Burst drain
    rdy8 = 1'b1;
    req8 = 8'b1010_0100;
    cyc();
    req8 = '0;
    chk("burst_pend", 32'(pend8), 32'hA4);
    chk("burst_lat_valid", 32'(v8), 32'd0);
    exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(2);
    drain(1'b0, 20);
    cyc();
    chk("burst_end_valid", 32'(v8), 32'd0);
    chk("burst_end_pend", 32'(pend8), 32'd0);

    // Backpressure
    rdy8 = 1'b0;
    req8 = 8'h80;
    cyc();
    req8 = '0;
    cyc();
    chk("bp_valid", 32'(v8), 32'd1);
    chk("bp_idx", 32'(idx8), 32'd7);
    req8 = 8'h08;
    cyc();
    req8 = '0;
    cyc();
    chk("bp_hold_idx", 32'(idx8), 32'd7);
    chk("bp_hold_valid", 32'(v8), 32'd1);
    chk("bp_hold_pend", 32'(pend8), 32'h08);
    exp_q.push_back(7); exp_q.push_back(3);
    rdy8 = 1'b1;
    drain(1'b0, 20);
    cyc();
    chk("bp_end_valid", 32'(v8), 32'd0);
    chk("bp_end_pend", 32'(pend8), 32'd0);

    // Request on the bit being loaded re-arms it without overflow
    req8 = 8'h10;
    cyc();
    cyc();
    req8 = '0;
    chk("rearm_ovf", 32'(ovf8), 32'd0);
    chk("rearm_pend", 32'(pend8), 32'h10);
    exp_q.push_back(4); exp_q.push_back(4);
    drain(1'b0, 20);
    cyc();
    chk("rearm_end_valid", 32'(v8), 32'd0);

    // Overflow with output stage stalled
    rdy8 = 1'b0;
    req8 = 8'h01;
    cyc();
    req8 = '0;
    cyc();
    req8 = 8'h10;
    cyc();
    chk("ovf_first", 32'(ovf8), 32'd0);
    cyc();
    req8 = '0;
    chk("ovf_pulse", 32'(ovf8), 32'd1);
    chk("ovf_pend", 32'(pend8), 32'h10);
    cyc();
    chk("ovf_drop", 32'(ovf8), 32'd0);
    exp_q.push_back(0); exp_q.push_back(4);
    rdy8 = 1'b1;
    drain(1'b0, 20);
    cyc();
    chk("ovf_once_valid", 32'(v8), 32'd0);
    chk("ovf_once_pend", 32'(pend8), 32'd0);

    // Mid-stream asynchronous reset with everything pending
    rdy8 = 1'b0;
    req8 = 8'hFF;
    cyc();
    cyc();
    req8 = '0;
    chk("pre_rst_pend", 32'(pend8), 32'hFF);
    chk("pre_rst_valid", 32'(v8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v8), 32'd0);
    chk("arst_idx", 32'(idx8), 32'd0);
    chk("arst_pend", 32'(pend8), 32'd0);
    chk("arst_ovf", 32'(ovf8), 32'd0);
    cyc();
    rst_n = 1'b1;
    rdy8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_valid", 32'(v8), 32'd0);
    end

    // Fairness with both ends requesting every cycle
    req8 = 8'b1000_0001;
    cyc();
`ifdef PRI_ENC_SCHED_RR_EN
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(7); exp_q.push_back(0);
    end
`else
    for (int i = 0; i < 6; i++) exp_q.push_back(7);
`endif
    drain(1'b0, 20);
    req8 = '0;
    chk("fair_pend", 32'(pend8), 32'h81);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();

    // Non-power-of-two instance
    chk("n5_idle_valid", 32'(v5), 32'd0);
    rdy5 = 1'b1;
    req5 = 5'b1_0011;
    cyc();
    req5 = '0;
    chk("n5_pend", 32'(pend5), 32'h13);
    exp_q.push_back(4); exp_q.push_back(1); exp_q.push_back(0);
    drain(1'b1, 20);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("n5_end_valid", 32'(v5), 32'd0);
    end
    chk("n5_end_pend", 32'(pend5), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pri_enc_sched.md
# pri_enc_sched

Parametrised, registered priority-encoder scheduler. It latches single-cycle request pulses from N sources into a pending vector. It then emits one pending index per cycle through a valid/ready output stage, clearing each bit as it is served. It is the sequential successor to the team's 8:3 combinational priority encoder and sits between interrupt/event sources and a single downstream consumer.

## Interface
Parameters:
- `N`, default 8: number of request inputs; N ≥ 2, need not be a power of two.
- `W`, default `$clog2(N)`: index width. Derived; never overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N: request pulses, sampled every edge. Bit i set means source i requests service once.
- `out_valid`, output, 1: the output stage holds a valid index.
- `out_ready`, input, 1: the consumer accepts `out_idx` on an edge where `out_valid && out_ready`.
- `out_idx`, output, W: index of the served source.
- `pending`, output, N: requests latched but not yet loaded into the output stage.
- `overflow`, output, 1: one-cycle pulse when a request hits a bit that is already pending.

## Operation
- Output stage FSM has two states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- Load condition: `load = (pending != 0) && (EMPTY || out_ready)`.
- On `load`, select index `s` from `pending`:
  - Fixed mode: highest set bit, bit N-1 has top priority.
  - Round-robin mode: see Configuration.
- Then `out_idx <= s`, `pending[s]` is cleared, and the FSM goes to or stays in FULL.
- FULL with `out_ready`=1 and `pending==0`: go to EMPTY. `out_idx` holds its last value.
- FULL with `out_ready`=0: `out_idx` and `out_valid` stay stable. No load occurs.
- Pending update each edge: `pending <= (pending & ~clr) | req`, where `clr` is the one-hot of `s` when `load`, else 0.
- Simultaneous events:
  - `req[s]` arriving on the same edge `s` is loaded: bit stays set (new request). No overflow.
  - `req[i]` with `pending[i]` already set and not being cleared: requests merge, and `overflow` pulses for one cycle after that edge.
  - `req[i]` while i is in the output stage: sets `pending[i]` normally. No overflow.
- Only indices 0..N-1 are ever emitted, including when N is not a power of two.

## Timing
- Reset values: `out_valid`=0, `out_idx`=0, `pending`=0, `overflow`=0, round-robin pointer=N-1.
- Reset mid-operation: all state is cleared immediately (asynchronous). Requests pending at reset are discarded.
- Latency:
  - `req` sampled at edge k appears in `pending` after k.
  - It can appear on `out_idx`/`out_valid` after edge k+1 at the earliest.
- Throughput: one index per cycle while `out_ready`=1 and `pending`≠0.
- `overflow` is registered and valid the cycle after the colliding edge.
- No combinational path from `req` or `out_ready` to any output.

## Configuration
- `PRI_ENC_SCHED_RR_EN` defined: round-robin selection is compiled in.
  - A pointer `p` (reset N-1) marks the highest-priority index.
  - Search order is p, p-1, …, 0, N-1, …, p+1.
  - After each load of `s`, `p <= (s==0) ? N-1 : s-1`.
- Macro undefined: fixed priority, MSB highest. No pointer register exists.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `pending`=8'hFF → all outputs 0 immediately. After release, no stale index is emitted.
- Burst drain, N=8, `out_ready`=1: `req`=8'b1010_0100 for one cycle → `out_idx`=7, 5, 2 on consecutive cycles. `out_valid` then drops and `pending`=0.
- Backpressure: hold `out_ready`=0 with `out_idx`=7 valid. Pulse `req`=8'h08 → `out_idx` stays 7. Release ready → order is 7 then 3.
- Overflow: `out_ready`=0, `req[4]` pulsed on two consecutive edges → `overflow` high for exactly one cycle. Index 4 is granted only once.
- Fairness: `req`=8'b1000_0001 every cycle, `out_ready`=1.
  - With `PRI_ENC_SCHED_RR_EN`: `out_idx` sequence is 7, 0, 7, 0, …
  - Without it: 7, 7, 7, … (bit 0 stays pending).
- Non-power-of-two: N=5, `req`=5'b1_0011 → indices 4, 1, 0, never an index ≥5.
